conv_encoder_frame: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder that turns one 8-bit message into one 16-bit coded word. It sits directly upstream of the PISO → Viterbi decoder → SIPO test chain: its `o_data` and `o_done` drive that chain's `i_data` and `i_start`, closing the loop so that a decoded byte equals the original message. It encodes one message bit per clock under a small FSM. It also exposes the coded symbols as a serial stream for direct decoder feeding.

---
 rtl/viterbi_pkg.sv | 15 +
 rtl/conv_enc_core.sv | 35 +++
 rtl/conv_encoder_frame.sv | 93 +++++++++
 tb/tb_conv_encoder_frame.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants for the rate-1/2, K=3 convolutional code and its encoder FSM.
// The decoder's branch metrics use the same generators, so they live only here.
package viterbi_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

endpackage

// File: rtl/conv_enc_core.sv
// Shift-register core of the convolutional encoder: holds {s1,s2} and registers {c0,c1}.
// i_clr together with i_en encodes i_bit from a zero state, so a frame starts without a dead cycle.
module conv_enc_core
    import viterbi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [1:0] o_sym
);

    logic [K-2:0] hist;
    logic [K-2:0] hist_eff;
    logic [K-1:0] win;

    always_comb begin
        hist_eff = i_clr ? {(K-1){1'b0}} : hist;
        win      = {i_bit, hist_eff};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist  <= '0;
            o_sym <= 2'b00;
        end else if (i_en) begin
            o_sym <= {^(win & G0), ^(win & G1)};
            hist  <= win[K-1:1];
        end else if (i_clr) begin
            hist  <= '0;
        end
    end

endmodule

// File: rtl/conv_encoder_frame.sv
// Frame-level rate-1/2 encoder: one SIZE_MSG-bit message in, one SIZE_CODE-bit coded word out.
// State | meaning: IDLE wait for i_start; ENCODE one symbol per cycle; DONE o_done pulse, may restart.
module conv_encoder_frame
    import viterbi_pkg::*;
#(
    parameter int SIZE_MSG  = 8,
    parameter int SIZE_CODE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_MSG-1:0]  i_data,
    output logic [SIZE_CODE-1:0] o_data,
    output logic                 o_done,
    output logic                 o_busy,
    output logic [1:0]           o_sym,
    output logic                 o_sym_valid
);

    localparam int CNT_W = (SIZE_MSG > 1) ? $clog2(SIZE_MSG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE_MSG - 1);

    enc_state_t            state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [SIZE_MSG-1:0]   msg_sr;
    logic [SIZE_CODE-1:0]  word_sr;
    logic                  start_ok;
    logic                  core_clr, core_en, core_bit;

    conv_enc_core u_core (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (core_clr),
        .i_en    (core_en),
        .i_bit   (core_bit),
        .o_sym   (o_sym)
    );

    // The first bit is encoded on the start edge itself, so cycle 1 already shows step 0.
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        core_clr  = 1'b0;
        core_en   = 1'b0;
        core_bit  = msg_sr[SIZE_MSG-1];
        case (state)
            IDLE, DONE: begin
                if (state == DONE) state_nxt = IDLE;
                if (i_start) begin
                    start_ok  = 1'b1;
                    state_nxt = ENCODE;
                    core_clr  = 1'b1;
                    core_en   = 1'b1;
                    core_bit  = i_data[SIZE_MSG-1];
                end
            end
            ENCODE: begin
                if (cnt == LAST) state_nxt = DONE;
                else             core_en   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            msg_sr      <= '0;
            word_sr     <= '0;
            o_data      <= '0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
            o_sym_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_done      <= (state_nxt == DONE);
            o_busy      <= (state_nxt == ENCODE);
            o_sym_valid <= (state_nxt == ENCODE);
            if (start_ok) begin
                msg_sr  <= i_data << 1;
                cnt     <= '0;
                word_sr <= '0;
            end else if (state == ENCODE) begin
                msg_sr  <= msg_sr << 1;
                cnt     <= cnt + 1'b1;
                word_sr <= {word_sr[SIZE_CODE-3:0], o_sym};
                if (cnt == LAST) o_data <= {word_sr[SIZE_CODE-3:0], o_sym};
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_frame.sv
// Directed bench for conv_encoder_frame: hand-computed coded words, symbol stream and timing.
module tb_conv_encoder_frame;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  data;
    logic [15:0] o_data;
    logic        o_done, o_busy, o_sym_valid;
    logic [1:0]  o_sym;

    int n_assert = 0;
    int n_fail   = 0;

    conv_encoder_frame #(.SIZE_MSG(8), .SIZE_CODE(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_data      (data),
        .o_data      (o_data),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_sym       (o_sym),
        .o_sym_valid (o_sym_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_encode(input logic [7:0] m);
        logic s1, s2, u;
        logic [15:0] w;
        s1 = 1'b0; s2 = 1'b0; w = '0;
        for (int k = 0; k < 8; k++) begin
            u = m[7-k];
            w = {w[13:0], u ^ s1 ^ s2, u ^ s2};
            s2 = s1;
            s1 = u;
        end
        return w;
    endfunction

    task automatic start_frame(input logic [7:0] d);
        @(negedge clk);
        data  = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called in cycle 1 of a frame; leaves the bench in cycle 10 (or cycle 1 of a chained frame).
    task automatic check_frame(input logic [15:0] exp, input logic [15:0] prev, input string tag,
                               input int glitch_k, input bit chain, input logic [7:0] nxt);
        for (int k = 0; k < 8; k++) begin
            check({tag, "_busy"}, o_busy, 1'b1);
            check({tag, "_valid"}, o_sym_valid, 1'b1);
            check({tag, "_sym"}, o_sym, exp[15-2*k -: 2]);
            check({tag, "_done_early"}, o_done, 1'b0);
            check({tag, "_held"}, o_data, prev);
            if (k == glitch_k) begin
                start = 1'b1;
                data  = 8'h00;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check({tag, "_done"}, o_done, 1'b1);
        check({tag, "_busy_done"}, o_busy, 1'b0);
        check({tag, "_word"}, o_data, exp);
        if (chain) begin
            start = 1'b1;
            data  = nxt;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (!chain) begin
            check({tag, "_done_pulse"}, o_done, 1'b0);
            check({tag, "_word_hold"}, o_data, exp);
            check({tag, "_idle_busy"}, o_busy, 1'b0);
        end
    endtask

    initial begin
        logic        saw_done;
        logic [7:0]  m;
        logic [15:0] prev;

        rst_n = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        #12;
        check("rst_data", o_data, 16'h0000);
        check("rst_done", o_done, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_valid", o_sym_valid, 1'b0);
        check("rst_sym", o_sym, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Reset in cycle 4 of a frame
        start_frame(8'hB0);
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy_pre", o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_data", o_data, 16'h0000);
        check("mid_done", o_done, 1'b0);
        check("mid_busy", o_busy, 1'b0);
        check("mid_valid", o_sym_valid, 1'b0);
        check("mid_sym", o_sym, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) saw_done = 1'b1;
        end
        check("mid_no_done", saw_done, 1'b0);

        start_frame(8'hB0);
        check_frame(16'hE170, 16'h0000, "b0", -1, 1'b0, 8'h00);
        start_frame(8'h80);
        check_frame(16'hEC00, 16'hE170, "x80", -1, 1'b0, 8'h00);
        start_frame(8'hFF);
        check_frame(16'hDAAA, 16'hEC00, "xff", -1, 1'b0, 8'h00);
        start_frame(8'h00);
        check_frame(16'h0000, 16'hDAAA, "x00", -1, 1'b0, 8'h00);

        // Back-to-back: second start sampled in the DONE cycle
        start_frame(8'hFF);
        check_frame(16'hDAAA, 16'h0000, "b2b0", -1, 1'b1, 8'h80);
        check_frame(16'hEC00, 16'hDAAA, "b2b1", -1, 1'b0, 8'h00);

        // Start pulse in cycle 4 must be ignored
        start_frame(8'hB0);
        check_frame(16'hE170, 16'hEC00, "ign", 3, 1'b0, 8'h00);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) saw_done = 1'b1;
        end
        check("ign_once", saw_done, 1'b0);

        prev = 16'hE170;
        for (int i = 0; i < 20; i++) begin
            m = 8'($urandom_range(0, 255));
            start_frame(m);
            check_frame(ref_encode(m), prev, "rnd", -1, 1'b0, 8'h00);
            prev = ref_encode(m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
